// File: rtl/adc_pkg.sv
// Shared definitions for the ADC front end (capture stage and sample filter).
//   ADC_DATA_W  : native ADC code width
//   acc_state_t : block accumulator state
package adc_pkg;

    localparam int unsigned ADC_DATA_W = 8;

    typedef enum logic {
        ACC_EMPTY = 1'b0,
        ACC_RUN   = 1'b1
    } acc_state_t;

endpackage

// File: rtl/adc_hyst_cmp.sv
// Registered set/clear threshold comparator with hysteresis.
//   clk, reset : clock, async active-high reset
//   clear      : synchronous return to the reset value
//   load       : result is a new value to evaluate this cycle
//   result     : value compared against the thresholds
//   above      : set at/above TH_HI, cleared at/below TH_LO, otherwise held
module adc_hyst_cmp
    import adc_pkg::*;
#(
    parameter int unsigned          DATA_W = ADC_DATA_W,
    parameter logic [DATA_W-1:0]    TH_HI  = 8'd160,
    parameter logic [DATA_W-1:0]    TH_LO  = 8'd96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] result,
    output logic              above
);

    logic above_q;
    logic above_d;

    always_comb begin
        above_d = above_q;
        if (clear) begin
            above_d = 1'b0;
        end else if (load) begin
            if (result >= TH_HI) begin
                above_d = 1'b1;
            end else if (result <= TH_LO) begin
                above_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            above_q <= 1'b0;
        end else begin
            above_q <= above_d;
        end
    end

    assign above = above_q;

endmodule

// File: rtl/adc_sample_filter.sv
// Block-averaging filter behind the ADC capture interface.
// Accumulates 2^LOG2_N samples, presents the truncated mean through a
// single valid/ready slot, and tracks running peak and a hysteresis flag.
//   clk, reset   : clock, async active-high reset
//   sample_valid : one-cycle strobe qualifying sample_data
//   sample_data  : ADC code
//   clear        : synchronous soft clear (wins over sample_valid)
//   avg_ready    : consumer takes avg_data this cycle
//   avg_valid    : avg_data holds an unconsumed result
//   avg_data     : block average
//   peak         : maximum sample since reset/clear
//   above        : hysteresis threshold flag
//   overrun      : sticky, a completed block was dropped
//
// Accumulator FSM:
//   state     | meaning
//   ACC_EMPTY | no samples of the current block accepted yet
//   ACC_RUN   | block in progress, acc holds the partial sum
module adc_sample_filter
    import adc_pkg::*;
#(
    parameter int unsigned          DATA_W = ADC_DATA_W,
    parameter int unsigned          LOG2_N = 3,
    parameter logic [DATA_W-1:0]    TH_HI  = 8'd160,
    parameter logic [DATA_W-1:0]    TH_LO  = 8'd96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              clear,
    input  logic              avg_ready,
    output logic              avg_valid,
    output logic [DATA_W-1:0] avg_data,
    output logic [DATA_W-1:0] peak,
    output logic              above,
    output logic              overrun
);

    localparam int unsigned ACC_W = DATA_W + LOG2_N;
    // A zero-width counter is not legal; with LOG2_N=0 the single bit stays 0.
    localparam int unsigned CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int unsigned N     = 1 << LOG2_N;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    acc_state_t        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              avg_valid_q, avg_valid_d;
    logic [DATA_W-1:0] avg_data_q, avg_data_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic              overrun_q, overrun_d;

    logic              accept;
    logic              block_done;
    logic              slot_free;
    logic              result_load;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] result;

    assign accept     = sample_valid && !clear;
    // cnt is 0 in ACC_EMPTY, so with N=1 the first sample already closes the block.
    assign block_done = accept && (cnt_q == CNT_LAST);
    assign acc_base   = (state_q == ACC_RUN) ? acc_q : '0;
    assign sum        = acc_base + ACC_W'(sample_data);
    assign result     = DATA_W'(sum >> LOG2_N);

    // The slot can take a new result if it is empty or being drained this cycle.
    assign slot_free   = !avg_valid_q || avg_ready;
    assign result_load = block_done && slot_free;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ACC_EMPTY;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            if (block_done) begin
                state_d = ACC_EMPTY;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = ACC_RUN;
                acc_d   = sum;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        avg_valid_d = avg_valid_q;
        avg_data_d  = avg_data_q;
        overrun_d   = overrun_q;
        if (clear) begin
            avg_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else if (block_done) begin
            if (slot_free) begin
                avg_valid_d = 1'b1;
                avg_data_d  = result;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (avg_valid_q && avg_ready) begin
            avg_valid_d = 1'b0;
        end
    end

    always_comb begin
        peak_d = peak_q;
        if (clear) begin
            peak_d = '0;
        end else if (sample_valid && (sample_data > peak_q)) begin
            peak_d = sample_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ACC_EMPTY;
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_valid_q <= 1'b0;
            avg_data_q  <= '0;
            peak_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_valid_q <= avg_valid_d;
            avg_data_q  <= avg_data_d;
            peak_q      <= peak_d;
            overrun_q   <= overrun_d;
        end
    end

    adc_hyst_cmp #(
        .DATA_W (DATA_W),
        .TH_HI  (TH_HI),
        .TH_LO  (TH_LO)
    ) u_hyst (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .load   (result_load),
        .result (result),
        .above  (above)
    );

    assign avg_valid = avg_valid_q;
    assign avg_data  = avg_data_q;
    assign peak      = peak_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_sample_filter.sv
module tb_adc_sample_filter;

    localparam int N     = 8;
    localparam int TH_HI = 160;
    localparam int TH_LO = 96;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_data = 8'd0;
    logic       clear = 1'b0;
    logic       avg_ready = 1'b0;
    logic       avg_valid;
    logic [7:0] avg_data;
    logic [7:0] peak;
    logic       above;
    logic       overrun;

    adc_sample_filter dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .clear        (clear),
        .avg_ready    (avg_ready),
        .avg_valid    (avg_valid),
        .avg_data     (avg_data),
        .peak         (peak),
        .above        (above),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a block is a list of samples, the result is its mean,
    // and the output is a one-deep buffer that drops results when full.
    int blk[$];
    int exp_q[$];
    bit m_full;
    int m_avg;
    int m_peak;
    bit m_above;
    bit m_overrun;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        blk.delete();
        exp_q.delete();
        m_full = 0; m_avg = 0; m_peak = 0; m_above = 0; m_overrun = 0;
    endtask

    task automatic model_edge(input bit v, input int d, input bit r, input bit c);
        int  avg;
        bit  got;
        bit  xfer;
        xfer = m_full && r;
        if (c) begin
            blk.delete();
            m_peak = 0; m_above = 0; m_overrun = 0;
            // A result discarded by clear without being read never reaches the monitor.
            if (m_full && !r) void'(exp_q.pop_back());
            m_full = 0;
            return;
        end
        got = 0;
        avg = 0;
        if (v) begin
            blk.push_back(d);
            if (d > m_peak) m_peak = d;
            if (blk.size() == N) begin
                avg = blk.sum() / N;
                got = 1;
                blk.delete();
            end
        end
        if (got) begin
            if (m_full && !r) begin
                m_overrun = 1;
            end else begin
                exp_q.push_back(avg);
                m_full = 1;
                m_avg  = avg;
                if (avg >= TH_HI) m_above = 1;
                else if (avg <= TH_LO) m_above = 0;
            end
        end else if (xfer) begin
            m_full = 0;
        end
    endtask

    task automatic check_state();
        chk("avg_valid", avg_valid, m_full);
        chk("avg_data",  avg_data,  m_avg);
        chk("peak",      peak,      m_peak);
        chk("above",     above,     m_above);
        chk("overrun",   overrun,   m_overrun);
    endtask

    // Inputs change 1 time unit after the rising edge; the model advances for
    // the upcoming edge; state is compared 1 unit after that edge.
    task automatic step(input bit v, input int d, input bit r, input bit c);
        sample_valid = v;
        sample_data  = 8'(d);
        avg_ready    = r;
        clear        = c;
        model_edge(v, d, r, c);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(0, 0, r, 0);
    endtask

    task automatic send_block(input int val, input bit r);
        for (int i = 0; i < N; i++) step(1, val, r, 0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        clear        = 1'b0;
        avg_ready    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_state();
    endtask

    // Scoreboard monitor: every observed transfer must match the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && avg_valid && avg_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", avg_data, 32'hFFFF_FFFF);
                end else begin
                    chk("xfer_data", avg_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1;
        do_reset();

        // 8 samples of 100 with the consumer ready
        send_block(100, 1);
        idle(2, 1);

        // ramp 0..7, then a full-scale block
        for (int i = 0; i < N; i++) step(1, i, 1, 0);
        idle(1, 1);
        send_block(255, 1);
        idle(1, 1);

        // hysteresis: 170, 120, 90, 100
        send_block(170, 1);
        send_block(120, 1);
        send_block(90, 1);
        send_block(100, 1);
        idle(1, 1);

        // backpressure: two blocks with no consumer, then drain
        send_block(50, 0);
        send_block(60, 0);
        idle(2, 0);
        idle(3, 1);
        step(0, 0, 1, 1);

        // reset mid-block
        for (int i = 0; i < 5; i++) step(1, 200, 1, 0);
        do_reset();
        send_block(40, 1);
        idle(1, 1);

        // clear beats a simultaneous sample
        step(1, 250, 1, 1);
        send_block(10, 1);
        idle(1, 1);

        // result completes while the slot drains in the same cycle
        step(0, 0, 0, 1);
        send_block(30, 0);
        for (int i = 0; i < N - 1; i++) step(1, 70, 0, 0);
        step(1, 70, 1, 0);
        idle(2, 1);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            bit v, r, c;
            int d;
            v = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 1) == 1) d = $urandom_range(0, 255);
            else d = ($urandom_range(0, 1) == 1) ? $urandom_range(150, 255) : $urandom_range(0, 110);
            step(v, d, r, c);
        end

        idle(4, 1);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_filter.md
Name: adc_sample_filter

Overview:
Block-averaging filter placed directly downstream of the ADC0808 capture interface. It accepts 8-bit samples qualified by a one-cycle valid strobe and accumulates 2^LOG2_N samples per block. Each completed block produces one averaged result through a valid/ready output slot. It also tracks a running peak and a hysteresis threshold flag, for the control/display logic further downstream.

Parameters:
DATA_W, 8, sample and result width
LOG2_N, 3, log2 of block length (N = 8 samples per average)
TH_HI, 8'd160, average at or above this value sets above
TH_LO, 8'd96, average at or below this value clears above (TH_LO < TH_HI required)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sample_valid  input  1  one-cycle strobe; sample_data valid this cycle
sample_data  input  DATA_W  captured ADC code
clear  input  1  synchronous soft clear
avg_ready  input  1  consumer accepts avg_data this cycle
avg_valid  output  1  avg_data holds an unconsumed result
avg_data  output  DATA_W  block average
peak  output  DATA_W  maximum sample since reset/clear
above  output  1  hysteresis threshold flag
overrun  output  1  sticky; a completed block was dropped

Behaviour:
- Reset (async): acc=0, cnt=0, state=ACC_EMPTY, avg_valid=0, avg_data=0, peak=0, above=0, overrun=0.
- Accumulator width DATA_W+LOG2_N (11 bits by default); it never overflows.
- Sample counter width LOG2_N; it wraps from N-1 to 0.
- Accumulator FSM:
  - ACC_EMPTY: first accepted sample loads acc=sample, cnt=1, go to ACC_RUN.
  - ACC_RUN: each accepted sample adds to acc and increments cnt.
  - When cnt==N-1 and sample_valid: compute result = (acc+sample)>>LOG2_N (truncating), then go to ACC_EMPTY.
  - For LOG2_N=0, every sample is a complete block.
- Output slot:
  - A result is loaded into avg_data and avg_valid=1 on the clock edge that accepts the Nth sample. avg_valid is seen the next cycle.
  - A transfer occurs on a cycle with avg_valid && avg_ready. avg_valid drops the next cycle unless a new result loads the same edge.
  - A new result arriving while avg_valid && !avg_ready is dropped: avg_data is unchanged and overrun is set.
  - A new result arriving while avg_valid && avg_ready loads normally with no overrun.
  - avg_data is stable while avg_valid=1 and the result has not been transferred.
- Hysteresis flag:
  - Evaluated only on loaded results, using the new average.
  - Set if avg >= TH_HI; clear if avg <= TH_LO; otherwise hold.
  - above updates on the same edge as avg_data.
- Peak:
  - On sample_valid, peak <= max(peak, sample_data), one-cycle latency.
  - After clear, the next sample loads peak unconditionally.
- clear:
  - Returns the block to reset values: acc, cnt, state, peak, above, overrun, avg_valid.
  - avg_data keeps its value.
  - clear beats a same-cycle sample_valid; that sample is discarded and affects neither acc nor peak.
- No combinational path from inputs to outputs.

Decomposition:
- Package adc_pkg: ADC_DATA_W=8 and the accumulator state enum (ACC_EMPTY, ACC_RUN).
- The ADC capture stage shares adc_pkg.
- One natural sub-module, adc_hyst_cmp: registered set/clear comparator taking a result and its load strobe, parameterised by TH_HI/TH_LO.

Test Plan:
- After reset, 8 samples of 100 with avg_ready=1 -> avg_valid pulses one cycle after the 8th strobe with avg_data=100; peak=100; above=0.
- Samples 0..7 -> avg_data=3 (sum 28>>3); then 8 samples of 255 -> avg_data=255, no overflow, peak=255, above=1.
- Hysteresis: three blocks averaging 170, 120, 90 -> above goes 1, 1, 0; a following block of 100 -> above stays 0.
- Backpressure: avg_ready=0 for two full blocks (50 then 60) -> avg_data holds 50 and overrun=1; raise avg_ready -> one transfer of 50; overrun stays 1 until clear.
- Reset mid-block after 5 samples of 200, then 8 samples of 40 -> avg_data=40; asserting clear alongside a sample of 250 -> peak stays 0 and cnt stays 0.
- With avg_valid=1, a new result completing in the same cycle as avg_ready=1 -> new value loads, avg_valid stays high, overrun=0.
